piso_serializer: RTL and testbench

Parallel-in serial-out transmitter for the serial link whose receive end is the 4-bit SIPO shift register. It accepts a WIDTH-bit word through a valid/ready load handshake and shifts it out one bit per `clk` cycle, with a per-bit valid and a last-bit marker. It supports back-to-back words with no idle gap, so a SIPO clocked on the same `clk` reconstructs each word after WIDTH edges.

---
 rtl/piso_pkg.sv | 7 +
 rtl/piso_bit_counter.sv | 20 ++
 rtl/piso_serializer.sv | 47 ++++
 tb/tb_piso_serializer.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// piso_pkg: shared state encoding and counter sizing for the PISO serializer
package piso_pkg;
  typedef enum logic {ST_IDLE, ST_SHIFT} piso_state_t;
  function automatic int cnt_width(input int w);
    return $clog2(w);
  endfunction
endpackage

// File: rtl/piso_bit_counter.sv
// piso_bit_counter: bit position counter with clear, enable and terminal-count flag
module piso_bit_counter
  import piso_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int CW = cnt_width(WIDTH);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
  assign tc = cnt == CW'(WIDTH - 1);
endmodule

// File: rtl/piso_serializer.sv
// piso_serializer: valid/ready loaded parallel-in serial-out transmitter
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] din,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_last
);
  piso_state_t      state;
  logic [WIDTH-1:0] sreg;
  logic             shifting;
  logic             last;
  logic             accept;
  assign shifting   = state == ST_SHIFT;
  assign load_ready = !rst && (!shifting || last);
  assign accept     = load_valid && load_ready;
  // Clearing on the last bit keeps the counter at zero through idle, so it never wraps
  piso_bit_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (accept || last),
    .en  (shifting),
    .tc  (last)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= ST_IDLE;
      sreg  <= '0;
    end else if (accept) begin
      state <= ST_SHIFT;
      sreg  <= din;
    end else if (shifting) begin
      sreg  <= MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};
      state <= last ? ST_IDLE : ST_SHIFT;
    end
  assign sout       = shifting && (MSB_FIRST ? sreg[WIDTH-1] : sreg[0]);
  assign sout_valid = shifting;
  assign sout_last  = shifting && last;
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: directed checks of the PISO serializer, both bit orders plus SIPO loopback
module tb_piso_serializer;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load_valid = 1'b0;
  logic       load_ready;
  logic [3:0] din = '0;
  logic       sout, sout_valid, sout_last;
  logic       lv1 = 1'b0;
  logic       rdy1;
  logic [3:0] din1 = '0;
  logic       sout1, sv1, sl1;
  logic [3:0] q;
  int         errors = 0;
  int         checks = 0;

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) u_dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready), .din(din),
    .sout(sout), .sout_valid(sout_valid), .sout_last(sout_last)
  );
  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .load_valid(lv1), .load_ready(rdy1), .din(din1),
    .sout(sout1), .sout_valid(sv1), .sout_last(sl1)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk)
    if (rst) q <= '0;
    else q <= {q[2:0], sout};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bit(input string tag, input logic b, input logic lst);
    chk({tag, ".sout"}, 32'(sout), 32'(b));
    chk({tag, ".valid"}, 32'(sout_valid), 32'd1);
    chk({tag, ".last"}, 32'(sout_last), 32'(lst));
    chk({tag, ".ready"}, 32'(load_ready), 32'(lst));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".sout"}, 32'(sout), 32'd0);
    chk({tag, ".valid"}, 32'(sout_valid), 32'd0);
    chk({tag, ".last"}, 32'(sout_last), 32'd0);
    chk({tag, ".ready"}, 32'(load_ready), 32'd1);
  endtask

  initial begin
    logic [3:0] w;
    logic [7:0] bb;
    #2;
    chk("rst.sout", 32'(sout), 32'd0);
    chk("rst.valid", 32'(sout_valid), 32'd0);
    chk("rst.last", 32'(sout_last), 32'd0);
    chk("rst.ready", 32'(load_ready), 32'd0);
    step();
    step();
    rst = 1'b0;
    #1;
    chk_idle("post_rst");

    // single word
    w = 4'b1011;
    din = w;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    din = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      chk_bit($sformatf("single%0d", i), w[3-i], i == 3);
      step();
    end
    chk_idle("single_end");

    // back-to-back with load_valid held high
    bb = 8'b1011_0110;
    din = 4'b1011;
    load_valid = 1'b1;
    step();
    for (int i = 0; i < 8; i++) begin
      chk_bit($sformatf("b2b%0d", i), bb[7-i], (i % 4) == 3);
      if (i == 3) din = 4'b0110;
      if (i == 7) load_valid = 1'b0;
      step();
    end
    chk_idle("b2b_end");

    // load attempt while busy is ignored
    w = 4'b1000;
    din = w;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk_bit($sformatf("busy%0d", i), w[3-i], i == 3);
      if (i == 1) begin
        load_valid = 1'b1;
        din = 4'b1111;
      end
      if (i == 2) load_valid = 1'b0;
      step();
    end
    chk_idle("busy_end");

    // reset mid-frame
    din = 4'b1101;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    chk_bit("mid0", 1'b1, 1'b0);
    step();
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst.sout", 32'(sout), 32'd0);
    chk("mid_rst.valid", 32'(sout_valid), 32'd0);
    chk("mid_rst.last", 32'(sout_last), 32'd0);
    chk("mid_rst.ready", 32'(load_ready), 32'd0);
    step();
    rst = 1'b0;
    #1;
    chk_idle("mid_rel");
    w = 4'b0011;
    din = w;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk_bit($sformatf("after_rst%0d", i), w[3-i], i == 3);
      step();
    end
    chk_idle("after_rst_end");

    // loopback into a 4-bit SIPO
    w = 4'b1011;
    din = w;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk_bit($sformatf("loop%0d", i), w[3-i], i == 3);
      step();
    end
    chk("loop.q", 32'(q), 32'hB);

    // LSB-first instance
    din1 = 4'b1011;
    lv1 = 1'b1;
    chk("lsb.ready", 32'(rdy1), 32'd1);
    step();
    lv1 = 1'b0;
    w = 4'b1011;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("lsb%0d.sout", i), 32'(sout1), 32'(w[i]));
      chk($sformatf("lsb%0d.valid", i), 32'(sv1), 32'd1);
      chk($sformatf("lsb%0d.last", i), 32'(sl1), 32'(i == 3));
      step();
    end
    chk("lsb_end.valid", 32'(sv1), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
